// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory responder.
// FSM encodings and the datapath word width.
package mips_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int WORD_W = 32;

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// Loadable 4-bit down-counter for wait states.
// done is high while the count sits at zero.
module wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign done = (cnt_q == 4'd0);

  // Load wins over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !done) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data RAM with wait states for the MIPS load/store port.
// Response data and flags are registered; ready pulses for one cycle.
module data_mem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] WD,
  output logic [WORD_W-1:0] RD,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW    = IDX_W + 2;
  localparam logic ZERO_WS = (WAIT_STATES == 0);
  localparam logic [3:0] LOAD_V =
    ZERO_WS ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     a_q, a_d;
  logic [WORD_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] rd_q, rd_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];

  logic              cnt_load, cnt_en, cnt_done;
  logic              go_resp, idle;
  logic [AW-1:0]     cur_a;
  logic [WORD_W-1:0] cur_wd;
  logic              cur_we;
  logic [IDX_W-1:0]  idx;
  logic              mis;
  logic              unused_a;

  assign unused_a = ^A[WORD_W-1:AW];

  wait_counter u_wait (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (LOAD_V),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  // With zero wait states the access completes on the accept
  // edge, so the live inputs stand in for the latched ones.
  assign idle   = (state_q == S_IDLE);
  assign cur_a  = idle ? A[AW-1:0] : a_q;
  assign cur_wd = idle ? WD : wd_q;
  assign cur_we = idle ? MemWrite : we_q;
  assign idx    = cur_a[AW-1:2];
  assign mis    = (cur_a[1:0] != 2'b00);

  // FSM next state and wait-counter control.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    go_resp  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (ZERO_WS) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d  = S_WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          state_d = S_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, memory update and response registers.
  always_comb begin
    a_d     = a_q;
    wd_d    = wd_q;
    we_d    = we_q;
    mem_d   = mem_q;
    rd_d    = rd_q;
    ready_d = go_resp;
    err_d   = 1'b0;
    if (idle && req) begin
      a_d  = A[AW-1:0];
      wd_d = WD;
      we_d = MemWrite;
    end
    if (go_resp) begin
      err_d = mis;
      if (mis) begin
        rd_d = '0;
      end else if (cur_we) begin
        mem_d[idx] = cur_wd;
        rd_d       = cur_wd;
      end else begin
        rd_d = mem_q[idx];
      end
    end
  end

  // State, latches, memory and outputs; reset clears all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign RD       = rd_q;
  assign ready    = ready_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
// Instances with 2 and 0 wait states share stimulus.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req0, req2;
  logic        MemWrite;
  logic [31:0] A, WD;
  logic [31:0] rd0, rd2;
  logic        rdy0, rdy2, err0, err2;

  int passed = 0;
  int total  = 0;

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .MemWrite(MemWrite),
    .A(A), .WD(WD), .RD(rd2), .ready(rdy2), .addr_err(err2)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .MemWrite(MemWrite),
    .A(A), .WD(WD), .RD(rd0), .ready(rdy0), .addr_err(err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic access(input int sel, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err,
                        output int lat);
    @(negedge clk);
    @(negedge clk);
    A = a; WD = wd; MemWrite = w;
    if (sel == 0) req0 = 1'b1;
    else          req2 = 1'b1;
    lat = 99; rd = 32'hx; err = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? rdy0 : rdy2) begin
        lat = i;
        rd  = (sel == 0) ? rd0 : rd2;
        err = (sel == 0) ? err0 : err2;
        break;
      end
    end
    req0 = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic err; int lat;
    reset = 1'b0;
    #23;
    total++;
    if (rdy2 !== 1'b0 || rd2 !== 32'h0 || err2 !== 1'b0)
      $display("FAIL reset_ws2: rdy=%b rd=%h err=%b want 0 0 0", rdy2, rd2, err2);
    else passed++;
    total++;
    if (rdy0 !== 1'b0 || rd0 !== 32'h0 || err0 !== 1'b0)
      $display("FAIL reset_ws0: rdy=%b rd=%h err=%b want 0 0 0", rdy0, rd0, err0);
    else passed++;
    @(negedge clk); reset = 1'b1;
    access(2, 1'b0, 32'h10, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'h0 || lat !== 3)
      $display("FAIL reset_load: rd=%h lat=%0d want 0 lat 3", rd, lat);
    else passed++;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic err; int lat;
    access(2, 1'b1, 32'h08, 32'hDEADBEEF, rd, err, lat);
    total++;
    if (lat !== 3)
      $display("FAIL store_latency: got %0d want 3", lat);
    else passed++;
    total++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0)
      $display("FAIL store_echo: rd=%h err=%b want deadbeef 0", rd, err);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (rdy2 !== 1'b0)
      $display("FAIL ready_pulse: got %b want 0", rdy2);
    else passed++;
    access(2, 1'b0, 32'h08, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hDEADBEEF || lat !== 3)
      $display("FAIL load_back: rd=%h lat=%0d want deadbeef 3", rd, lat);
    else passed++;
  endtask

  task automatic test_zero_wait;
    logic [31:0] rd; logic err; int lat;
    logic exp_rdy;
    access(0, 1'b0, 32'h10, 32'h0, rd, err, lat);
    total++;
    if (lat !== 1 || rd !== 32'h0)
      $display("FAIL ws0_load: lat=%0d rd=%h want 1 0", lat, rd);
    else passed++;
    access(0, 1'b1, 32'h04, 32'hCAFEF00D, rd, err, lat);
    total++;
    if (lat !== 1 || rd !== 32'hCAFEF00D)
      $display("FAIL ws0_store: lat=%0d rd=%h want 1 cafef00d", lat, rd);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    A = 32'h04; MemWrite = 1'b0; req0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      exp_rdy = (i % 2) == 1;
      total++;
      if (rdy0 !== exp_rdy || (exp_rdy && rd0 !== 32'hCAFEF00D))
        $display("FAIL b2b_%0d: rdy=%b rd=%h want %b cafef00d",
                 i, rdy0, rd0, exp_rdy);
      else passed++;
    end
    req0 = 1'b0;
  endtask

  task automatic test_alias;
    logic [31:0] rd; logic err; int lat;
    access(2, 1'b1, 32'h100, 32'h12345678, rd, err, lat);
    access(2, 1'b0, 32'h000, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'h12345678)
      $display("FAIL alias: rd=%h want 12345678", rd);
    else passed++;
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic err; int lat;
    access(2, 1'b1, 32'h0A, 32'hFFFFFFFF, rd, err, lat);
    total++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 3)
      $display("FAIL misaligned: err=%b rd=%h lat=%0d want 1 0 3", err, rd, lat);
    else passed++;
    access(2, 1'b0, 32'h08, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0)
      $display("FAIL mis_nowrite: rd=%h err=%b want deadbeef 0", rd, err);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic err; int lat;
    logic seen;
    @(negedge clk);
    @(negedge clk);
    A = 32'h20; WD = 32'hA5A5A5A5; MemWrite = 1'b1; req2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    req2 = 1'b0;
    #1;
    total++;
    if (rdy2 !== 1'b0 || rd2 !== 32'h0)
      $display("FAIL mid_reset_out: rdy=%b rd=%h want 0 0", rdy2, rd2);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) reset = 1'b1;
      if (rdy2 === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL mid_reset_ready: pulsed=%b want 0", seen);
    else passed++;
    access(2, 1'b0, 32'h20, 32'h0, rd, err, lat);
    total++;
    if (rd !== 32'h0 || lat !== 3)
      $display("FAIL mid_reset_mem: rd=%h lat=%0d want 0 3", rd, lat);
    else passed++;
  endtask

  initial begin
    req0 = 1'b0; req2 = 1'b0; MemWrite = 1'b0;
    A = '0; WD = '0; reset = 1'b0;
    test_reset();
    test_store_load();
    test_zero_wait();
    test_alias();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
